mem_dma: RTL

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma_pkg.sv | 31 +++
 rtl/mem_dma_regs.sv | 86 ++++++++
 rtl/mem_dma.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory-to-memory DMA: register indices,
// STATUS/CTRL bit positions, bus strobe encodings and the FSM state encoding.
package mem_dma_pkg;

  localparam logic [3:0] REG_SRC    = 4'd0;
  localparam logic [3:0] REG_DST    = 4'd1;
  localparam logic [3:0] REG_LEN    = 4'd2;
  localparam logic [3:0] REG_CTRL   = 4'd3;
  localparam logic [3:0] REG_STATUS = 4'd4;
  localparam logic [3:0] REG_COUNT  = 4'd5;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERROR   = 2;
  localparam int ST_ABORTED = 3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam logic [3:0] WSTRB_RD = 4'h0;
  localparam logic [3:0] WSTRB_WR = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RD_GAP = 3'd2,
    S_WR     = 3'd3,
    S_WR_GAP = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dma_regs.sv
// CPU-facing register block: SRC/DST/LEN storage, read mux and the
// start/abort strobes qualified against the engine's busy state.
module mem_dma_regs
  import mem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  input  logic             busy,
  input  logic             done,
  input  logic             error,
  input  logic             aborted,
  input  logic [LEN_W-1:0] count,
  output logic [31:0]      rdata,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             start,
  output logic             abort
);

  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ctrl_wr;
  logic [31:0]      status;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
    end
  end

  // Transfer parameters are frozen while the engine is running.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    if (we && !busy) begin
      case (addr)
        REG_SRC: src_d = {wdata[31:2], 2'b00};
        REG_DST: dst_d = {wdata[31:2], 2'b00};
        REG_LEN: len_d = wdata[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  assign ctrl_wr = we && (addr == REG_CTRL);
  assign start   = ctrl_wr && wdata[CTRL_START] && !wdata[CTRL_ABORT] && !busy;
  assign abort   = ctrl_wr && wdata[CTRL_ABORT] && busy;

  always_comb begin
    status             = '0;
    status[ST_BUSY]    = busy;
    status[ST_DONE]    = done;
    status[ST_ERROR]   = error;
    status[ST_ABORTED] = aborted;
  end

  always_comb begin
    case (addr)
      REG_SRC:    rdata = src_q;
      REG_DST:    rdata = dst_q;
      REG_LEN:    rdata = 32'(len_q);
      REG_STATUS: rdata = status;
      REG_COUNT:  rdata = 32'(count);
      default:    rdata = '0;
    endcase
  end

  assign src = src_q;
  assign dst = dst_q;
  assign len = len_q;

endmodule

// File: rtl/mem_dma.sv
// Word-copy DMA engine: read one word, write it back, repeat for LEN words,
// with per-access timeout and abort honoured at the gap cycles.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int LEN_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        irq
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [31:0]      src_ptr_q, src_ptr_d;
  logic [31:0]      dst_ptr_q, dst_ptr_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             aborted_q, aborted_d;
  logic             irq_q, irq_d;
  logic             abort_pend_q, abort_pend_d;

  logic             busy, start_stb, abort_stb, abort_now, to_expired;
  logic [31:0]      src_reg, dst_reg;
  logic [LEN_W-1:0] len_reg;

  assign busy = (state_q != S_IDLE);

  mem_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done_q),
    .error   (error_q),
    .aborted (aborted_q),
    .count   (count_q),
    .rdata   (rdata),
    .src     (src_reg),
    .dst     (dst_reg),
    .len     (len_reg),
    .start   (start_stb),
    .abort   (abort_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      to_q         <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      aborted_q    <= 1'b0;
      irq_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      to_q         <= to_d;
      done_q       <= done_d;
      error_q      <= error_d;
      aborted_q    <= aborted_d;
      irq_q        <= irq_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Datapath registers are only observed on the bus in RD/WR, so they need no reset.
  always_ff @(posedge clk) begin
    src_ptr_q <= src_ptr_d;
    dst_ptr_q <= dst_ptr_d;
    data_q    <= data_d;
  end

  assign abort_now  = abort_pend_q || abort_stb;
  assign to_expired = (to_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    data_d       = data_q;
    count_d      = count_q;
    to_d         = to_q;
    done_d       = done_q;
    error_d      = error_q;
    aborted_d    = aborted_q;
    irq_d        = 1'b0;
    abort_pend_d = abort_pend_q || abort_stb;
    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start_stb) begin
          src_ptr_d = src_reg;
          dst_ptr_d = dst_reg;
          count_d   = len_reg;
          to_d      = '0;
          error_d   = 1'b0;
          aborted_d = 1'b0;
          if (len_reg == '0) begin
            done_d = 1'b1;
            irq_d  = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_RD, S_WR: begin
        if (m_ready) begin
          to_d = '0;
          if (state_q == S_RD) begin
            data_d  = m_rdata;
            state_d = S_RD_GAP;
          end else begin
            src_ptr_d = src_ptr_q + 32'd4;
            dst_ptr_d = dst_ptr_q + 32'd4;
            count_d   = count_q - 1'b1;
            state_d   = S_WR_GAP;
          end
        end else if (to_expired) begin
          to_d         = '0;
          error_d      = 1'b1;
          irq_d        = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_RD_GAP, S_WR_GAP: begin
        if (abort_now) begin
          aborted_d    = 1'b1;
          irq_d        = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = S_IDLE;
        end else if (state_q == S_RD_GAP) begin
          state_d = S_WR;
        end else if (count_q == '0) begin
          done_d  = 1'b1;
          irq_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are a pure function of state and held registers, so they stay stable while stalled.
  always_comb begin
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = WSTRB_RD;
    case (state_q)
      S_RD: begin
        m_valid = 1'b1;
        m_addr  = src_ptr_q;
      end
      S_WR: begin
        m_valid = 1'b1;
        m_addr  = dst_ptr_q;
        m_wdata = data_q;
        m_wstrb = WSTRB_WR;
      end
      default: ;
    endcase
  end

  assign irq = irq_q;

endmodule
